// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the five-stage RISC-V pipeline. The stage owns
// the program counter. It issues one instruction-memory request at a time
// and loads the IF/ID pipeline register that feeds decode.
//
// It also follows two control inputs:
//   - A load-use stall from the hazard controller freezes IF/ID. A response
//     that arrives during the stall is parked in a one-entry hold buffer, so
//     no instruction is lost.
//   - An EX-stage redirect flushes IF/ID to a bubble, moves the PC to the
//     target, and squashes any fetch that is still in flight.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned)
//   NOP_INST        bubble instruction word (addi x0,x0,0)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   stall_flag      load-use stall; freezes IF/ID
//   redirect_valid  taken branch/jump resolved in EX
//   redirect_pc     redirect target; bits [1:0] are ignored
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_ready      memory accepts the request when imem_req && imem_ready
//   imem_rvalid     response valid, one per accepted request
//   imem_rdata      response instruction word
//   if_inst         IF/ID instruction word
//   if_pc           IF/ID PC (meaningless while if_valid is 0)
//   if_valid        IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_flag,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    // ST_REQ     : request for pc is presented to memory
    // ST_WAIT    : request accepted, response owed for pc
    // ST_HOLD    : response captured during a stall, waiting for release
    // ST_DISCARD : response owed but stale (squashed by a redirect)
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    logic [31:0] hold_inst;
    logic [31:0] hold_pc;

    logic        accept;        // request handshake completes this cycle
    logic        deliver;       // an instruction goes into IF/ID this cycle
    logic        capture;       // response is parked in the hold buffer
    logic [31:0] deliver_inst;
    logic [31:0] deliver_pc;

    // Redirect targets are always word aligned; low bits are dropped here
    // so both the PC and the flushed IF/ID see the aligned value.
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 becomes 0.
    assign pc_plus4 = pc + 32'd4;

    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output is given a default before the case
    // statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                // A redirect in the same cycle as acceptance leaves a stale
                // response outstanding. That response must be drained.
                if (accept) begin
                    state_next = redirect_valid ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (stall_flag && !redirect_valid) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_REQ;
                    end
                end else if (redirect_valid) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !stall_flag) begin
                    state_next = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath-control logic
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req     = 1'b0;
        deliver      = 1'b0;
        capture      = 1'b0;
        deliver_inst = hold_inst;
        deliver_pc   = hold_pc;
        case (state)
            ST_REQ: begin
                // The request is gated by reset, so no request leaves the
                // stage while the memory itself is being reset.
                imem_req = !rst;
            end
            ST_WAIT: begin
                // A response that meets a redirect is simply dropped.
                if (imem_rvalid && !redirect_valid) begin
                    if (stall_flag) begin
                        capture = 1'b1;
                    end else begin
                        deliver      = 1'b1;
                        deliver_inst = imem_rdata;
                        deliver_pc   = pc;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_flag && !redirect_valid) begin
                    deliver = 1'b1;
                end
            end
            default: begin
                // ST_DISCARD drives nothing; the stale data is ignored.
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Program counter
    // -----------------------------------------------------------------------
    // The PC keeps the address of the outstanding fetch. It advances only
    // when that fetch's instruction actually enters IF/ID.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (deliver) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // -----------------------------------------------------------------------
    // Hold buffer
    // -----------------------------------------------------------------------
    // NOTE: the hold buffer is a plain data register with no reset. It is
    // only read in ST_HOLD, and that state is entered only through a capture
    // that writes it first.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_inst <= imem_rdata;
            hold_pc   <= pc;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    // Priority: redirect flush, then stall freeze, then delivery, then bubble.
    // A redirect flushes IF/ID even while the stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst  <= NOP_INST;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
        end else if (redirect_valid) begin
            if_inst  <= NOP_INST;
            if_pc    <= redirect_target;
            if_valid <= 1'b0;
        end else if (stall_flag) begin
            if_inst  <= if_inst;
            if_pc    <= if_pc;
            if_valid <= if_valid;
        end else if (deliver) begin
            if_inst  <= deliver_inst;
            if_pc    <= deliver_pc;
            if_valid <= 1'b1;
        end else begin
            if_inst  <= NOP_INST;
            if_pc    <= pc;
            if_valid <= 1'b0;
        end
    end

endmodule
